// File: rtl/nr_recip_unit.sv
// Streaming Newton-Raphson reciprocal: normalise by leading one, linear seed, NR on one
// shared multiplier, saturating denormalise, then replay the result a programmable number of beats.
`timescale 1ns/1ps
module nr_recip_unit #(
    parameter int DWIDTH     = 16,
    parameter int FRAC_BIT   = 11,
    parameter int ITERATIONS = 3,
    parameter int CNT_BIT    = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DWIDTH-1:0]  i_data,
    input  logic [CNT_BIT-1:0] i_repeat,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DWIDTH-1:0]  o_data,
    output logic               o_last,
    output logic               o_div_zero,
    output logic               o_sat
);
    localparam int PW    = $clog2(DWIDTH);
    localparam int EW    = PW + 1;
    localparam int ITW   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int PWIDE = 2 * DWIDTH;
    // Seed y0 = 48/17 - 32/17*m, constants rounded to nearest in Q.FRAC_BIT
    localparam logic signed [DWIDTH-1:0] C1  = DWIDTH'((32'sd96 * (32'sd1 <<< FRAC_BIT) + 32'sd17) / 32'sd34);
    localparam logic signed [DWIDTH-1:0] C2  = DWIDTH'((32'sd64 * (32'sd1 <<< FRAC_BIT) + 32'sd17) / 32'sd34);
    localparam logic signed [DWIDTH-1:0] TWO = DWIDTH'(32'sd2 <<< FRAC_BIT);
    localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic signed [PWIDE-1:0] MAX_WIDE = {{(DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_MUL1  = 3'd2,
        S_MUL2  = 3'd3,
        S_SCALE = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [DWIDTH-1:0]         x_q, x_d;
    logic [CNT_BIT-1:0]        cnt_q, cnt_d;
    logic [ITW-1:0]            it_q, it_d;
    logic                      sgn_q, sgn_d, zero_q, zero_d;
    logic signed [EW-1:0]      e_q, e_d;
    logic signed [DWIDTH-1:0]  m_q, m_d, y_q, y_d, t_q, t_d;
    logic                      o_ready_q, o_ready_d, o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic                      o_div_zero_q, o_div_zero_d, o_sat_q, o_sat_d;
    logic [DWIDTH-1:0]         o_data_q, o_data_d;

    logic [DWIDTH-1:0]         abs_s, m_s, mag_s, res_s;
    logic [PW-1:0]             lead_s;
    logic signed [EW-1:0]      e_s, neg_e_s;
    logic signed [DWIDTH-1:0]  mul_a_s, mul_b_s, mul_res_s;
    logic signed [PWIDE-1:0]   prod_s, y_wide_s, scaled_s;
    logic                      sat_s;

    // Operand normalisation: magnitude, leading-one index, mantissa in [0.5,1)
    always_comb begin
        if (x_q[DWIDTH-1]) begin
            abs_s = (x_q == MINV) ? MAXV : (~x_q + {{(DWIDTH-1){1'b0}}, 1'b1});
        end else begin
            abs_s = x_q;
        end
        lead_s = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            lead_s = abs_s[i] ? PW'(i) : lead_s;
        end
        if (lead_s >= PW'(FRAC_BIT - 1)) begin
            m_s = abs_s >> (lead_s - PW'(FRAC_BIT - 1));
        end else begin
            m_s = abs_s << (PW'(FRAC_BIT - 1) - lead_s);
        end
        e_s = EW'(lead_s) - EW'(FRAC_BIT - 1);
    end

    // Shared signed multiplier operand selection
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        case (state_q)
            S_NORM:  begin mul_a_s = m_s; mul_b_s = C2;         end
            S_MUL1:  begin mul_a_s = m_q; mul_b_s = y_q;        end
            S_MUL2:  begin mul_a_s = y_q; mul_b_s = TWO - t_q;  end
            default: begin mul_a_s = '0;  mul_b_s = '0;         end
        endcase
    end

    assign prod_s    = mul_a_s * mul_b_s;
    assign mul_res_s = DWIDTH'(prod_s >>> FRAC_BIT);

    // Denormalise the converged estimate, saturate, restore sign
    always_comb begin
        y_wide_s = PWIDE'(y_q);
        neg_e_s  = -e_q;
        if (!e_q[EW-1] && (e_q != '0)) begin
            scaled_s = y_wide_s >>> $unsigned(e_q);
        end else begin
            scaled_s = y_wide_s <<< $unsigned(neg_e_s);
        end
        if (scaled_s > MAX_WIDE) begin
            mag_s = MAXV;
            sat_s = 1'b1;
        end else begin
            mag_s = scaled_s[DWIDTH-1:0];
            sat_s = 1'b0;
        end
        res_s = sgn_q ? (~mag_s + {{(DWIDTH-1){1'b0}}, 1'b1}) : mag_s;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        cnt_d        = cnt_q;
        it_d         = it_q;
        sgn_d        = sgn_q;
        zero_d       = zero_q;
        e_d          = e_q;
        m_d          = m_q;
        y_d          = y_q;
        t_d          = t_q;
        o_ready_d    = o_ready_q;
        o_valid_d    = o_valid_q;
        o_last_d     = o_last_q;
        o_div_zero_d = o_div_zero_q;
        o_sat_d      = o_sat_q;
        o_data_d     = o_data_q;
        if (i_flush) begin
            state_d   = S_IDLE;
            o_ready_d = 1'b1;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid && o_ready_q) begin
                        x_d       = i_data;
                        cnt_d     = (i_repeat == '0) ? CNT_BIT'(1) : i_repeat;
                        state_d   = S_NORM;
                        o_ready_d = 1'b0;
                    end else begin
                        o_ready_d = 1'b1;
                    end
                end
                S_NORM: begin
                    sgn_d   = x_q[DWIDTH-1];
                    zero_d  = (x_q == '0);
                    e_d     = e_s;
                    m_d     = m_s;
                    y_d     = C1 - mul_res_s;
                    it_d    = '0;
                    state_d = S_MUL1;
                end
                S_MUL1: begin
                    t_d     = mul_res_s;
                    state_d = S_MUL2;
                end
                S_MUL2: begin
                    y_d = mul_res_s;
                    if (it_q == ITW'(ITERATIONS - 1)) begin
                        state_d = S_SCALE;
                    end else begin
                        it_d    = it_q + ITW'(1);
                        state_d = S_MUL1;
                    end
                end
                S_SCALE: begin
                    o_valid_d    = 1'b1;
                    o_last_d     = (cnt_q == CNT_BIT'(1));
                    o_div_zero_d = zero_q;
                    o_sat_d      = !zero_q && sat_s;
                    o_data_d     = zero_q ? MAXV : res_s;
                    state_d      = S_OUT;
                end
                S_OUT: begin
                    if (i_ready) begin
                        if (cnt_q == CNT_BIT'(1)) begin
                            o_valid_d = 1'b0;
                            o_last_d  = 1'b0;
                            o_ready_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            cnt_d    = cnt_q - CNT_BIT'(1);
                            o_last_d = (cnt_q == CNT_BIT'(2));
                        end
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    o_valid_d = 1'b0;
                    o_last_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            cnt_q        <= '0;
            it_q         <= '0;
            sgn_q        <= 1'b0;
            zero_q       <= 1'b0;
            e_q          <= '0;
            m_q          <= '0;
            y_q          <= '0;
            t_q          <= '0;
            o_ready_q    <= 1'b0;
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_div_zero_q <= 1'b0;
            o_sat_q      <= 1'b0;
            o_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            cnt_q        <= cnt_d;
            it_q         <= it_d;
            sgn_q        <= sgn_d;
            zero_q       <= zero_d;
            e_q          <= e_d;
            m_q          <= m_d;
            y_q          <= y_d;
            t_q          <= t_d;
            o_ready_q    <= o_ready_d;
            o_valid_q    <= o_valid_d;
            o_last_q     <= o_last_d;
            o_div_zero_q <= o_div_zero_d;
            o_sat_q      <= o_sat_d;
            o_data_q     <= o_data_d;
        end
    end

    assign o_ready    = o_ready_q;
    assign o_valid    = o_valid_q;
    assign o_last     = o_last_q;
    assign o_div_zero = o_div_zero_q;
    assign o_sat      = o_sat_q;
    assign o_data     = o_data_q;
endmodule

// File: tb/tb_nr_recip_unit.sv
// Self-checking bench for nr_recip_unit: directed scenarios plus a random sweep against
// an arithmetic reciprocal reference with replay-beat accounting.
`timescale 1ns/1ps
module tb_nr_recip_unit;
    localparam int DW  = 16;
    localparam int FB  = 11;
    localparam int IT  = 3;
    localparam int CB  = 16;
    localparam int LAT = 2 * IT + 2;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [CB-1:0] i_repeat = '0;
    logic          o_ready, o_valid, o_last, o_div_zero, o_sat;
    logic [DW-1:0] o_data;
    int            checks = 0;
    int            failures = 0;

    localparam logic [DW-1:0] CORNERS [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                              16'hFFFF, 16'h0080, 16'h0081, 16'hFF7F};

    always #5 clk = ~clk;

    nr_recip_unit #(.DWIDTH(DW), .FRAC_BIT(FB), .ITERATIONS(IT), .CNT_BIT(CB)) dut (
        .clk(clk), .arst_n(arst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_repeat(i_repeat), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_div_zero(o_div_zero), .o_sat(o_sat)
    );

    // Reference: round(2^(2*FB)/|x|) with saturation; the internal estimate carries FB fraction
    // bits, so for small operands its last-bit error is magnified by the left denormalise shift.
    function automatic void ref_recip(input logic [DW-1:0] x, output int exp_v, output int tol,
                                      output bit exp_sat, output bit exp_dz);
        int xs, mag, k;
        xs      = int'($signed(x));
        exp_dz  = (x == '0);
        exp_sat = 1'b0;
        tol     = 0;
        exp_v   = (1 << (DW - 1)) - 1;
        if (!exp_dz) begin
            mag = (xs < 0) ? -xs : xs;
            if (mag > (1 << (DW - 1)) - 1) mag = (1 << (DW - 1)) - 1;
            if (mag * (1 << (DW - 1)) <= (1 << (2 * FB))) begin
                exp_sat = 1'b1;
            end else begin
                exp_v = ((1 << (2 * FB + 1)) + mag) / (2 * mag);
                k     = (FB - 1) - ($clog2(mag + 1) - 1);
                tol   = (k > 0) ? (2 << k) : 2;
            end
            if (xs < 0) exp_v = -exp_v;
        end
    endfunction

    task automatic send(input logic [DW-1:0] x, input logic [CB-1:0] rep);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        i_valid = 1'b1; i_data = x; i_repeat = rep;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (o_valid !== 1'b1 && lat < 40);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_ready, o_valid, o_last, o_div_zero, o_sat, o_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%b_%b_%b_%b_%h exp=all zero",
                     o_ready, o_valid, o_last, o_div_zero, o_sat, o_data);
        end
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release o_ready=%b o_valid=%b exp 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        int lat, exp_v, tol, got;
        bit exp_sat, exp_dz;
        i_ready = 1'b1;
        send(16'h1000, 16'd1);
        wait_valid(lat);
        ref_recip(16'h1000, exp_v, tol, exp_sat, exp_dz);
        got = int'($signed(o_data));
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (got > exp_v + tol || got < exp_v - tol) begin
            failures++; $display("FAIL basic_data got=%h exp=%h tol=%0d", o_data, DW'(exp_v), tol);
        end
        checks++;
        if ({o_last, o_div_zero, o_sat, o_ready} !== 4'b1000) begin
            failures++; $display("FAIL basic_flags last,dz,sat,ready got=%b exp=1000",
                                 {o_last, o_div_zero, o_sat, o_ready});
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++; $display("FAIL basic_b2b o_valid=%b o_ready=%b exp 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_replay();
        int lat, exp_v, tol, got, beats;
        bit exp_sat, exp_dz;
        logic [DW-1:0] first;
        i_ready = 1'b0;
        send(16'hE000, 16'd3);
        wait_valid(lat);
        ref_recip(16'hE000, exp_v, tol, exp_sat, exp_dz);
        first = o_data;
        got   = int'($signed(o_data));
        checks++;
        if (lat !== LAT || got > exp_v + tol || got < exp_v - tol) begin
            failures++; $display("FAIL replay_first lat=%0d data=%h exp lat=%0d data=%h", lat, o_data, LAT, DW'(exp_v));
        end
        beats = 0;
        for (int c = 0; c < 30 && beats < 3; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== first || o_last !== (beats == 2)) begin
                failures++;
                $display("FAIL replay_beat beat=%0d valid=%b data=%h last=%b exp 1 %h %b",
                         beats, o_valid, o_data, o_last, first, (beats == 2));
            end
            i_ready = (c % 2 == 0);
            if (i_ready) beats++;
            @(negedge clk);
        end
        checks++;
        if (beats !== 3 || o_valid !== 1'b0) begin
            failures++; $display("FAIL replay_count beats=%0d valid_after=%b exp 3 0", beats, o_valid);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_corners();
        int lat, exp_v, tol, got;
        bit exp_sat, exp_dz;
        i_ready = 1'b1;
        foreach (CORNERS[n]) begin
            send(CORNERS[n], 16'd0);
            wait_valid(lat);
            ref_recip(CORNERS[n], exp_v, tol, exp_sat, exp_dz);
            got = int'($signed(o_data));
            checks++;
            if (lat !== LAT || got > exp_v + tol || got < exp_v - tol || o_last !== 1'b1 ||
                o_sat !== exp_sat || o_div_zero !== exp_dz) begin
                failures++;
                $display("FAIL corner x=%h lat=%0d data=%h sat=%b dz=%b last=%b exp lat=%0d data=%h+-%0d sat=%b dz=%b last=1",
                         CORNERS[n], lat, o_data, o_sat, o_div_zero, o_last, LAT, DW'(exp_v), tol, exp_sat, exp_dz);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        int lat, exp_v, tol, got;
        bit exp_sat, exp_dz, seen;
        i_ready = 1'b1;
        send(16'h3000, 16'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++; $display("FAIL flush_idle o_ready=%b o_valid=%b exp 1 0", o_ready, o_valid);
        end
        // Flush in the same cycle as an accept must win
        i_valid = 1'b1; i_flush = 1'b1; i_data = 16'h1000; i_repeat = 16'd1;
        @(posedge clk);
        #1 i_valid = 1'b0; i_flush = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | (o_valid === 1'b1) | (o_ready !== 1'b1);
        end
        checks++;
        if (seen) begin failures++; $display("FAIL flush_no_output got output or busy exp none"); end
        send(16'h0800, 16'd1);
        wait_valid(lat);
        ref_recip(16'h0800, exp_v, tol, exp_sat, exp_dz);
        got = int'($signed(o_data));
        checks++;
        if (lat !== LAT || got > exp_v + tol || got < exp_v - tol) begin
            failures++; $display("FAIL flush_next lat=%0d data=%h exp lat=%0d data=%h", lat, o_data, LAT, DW'(exp_v));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        i_ready = 1'b0;
        send(16'h1000, 16'd2);
        wait_valid(lat);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_valid, o_last, o_div_zero, o_sat, o_data} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs valid=%b data=%h last=%b exp all zero", o_valid, o_data, o_last);
        end
        @(negedge clk);
        arst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready got=%b exp=1", o_ready); end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | (o_valid === 1'b1);
        end
        checks++;
        if (seen) begin failures++; $display("FAIL reset_mid_beat got output beat exp none"); end
    endtask

    task automatic test_random();
        int lat, exp_v, tol, got, nb, want;
        bit exp_sat, exp_dz, bad;
        logic [DW-1:0] x, first;
        logic [CB-1:0] rep;
        i_ready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            x   = DW'($urandom_range(1, 65535));
            rep = CB'($urandom_range(0, 2));
            want = (rep == '0) ? 1 : int'(rep);
            send(x, rep);
            wait_valid(lat);
            ref_recip(x, exp_v, tol, exp_sat, exp_dz);
            got = int'($signed(o_data));
            checks++;
            if (lat !== LAT || got > exp_v + tol || got < exp_v - tol || o_sat !== exp_sat || o_div_zero !== exp_dz) begin
                failures++;
                $display("FAIL rand_result x=%h lat=%0d data=%h sat=%b dz=%b exp lat=%0d data=%h+-%0d sat=%b dz=%b",
                         x, lat, o_data, o_sat, o_div_zero, LAT, DW'(exp_v), tol, exp_sat, exp_dz);
            end
            first = o_data;
            nb = 0;
            bad = 1'b0;
            while (o_valid === 1'b1 && nb < 8) begin
                bad = bad | (o_data !== first) | (o_last !== (nb == want - 1));
                nb++;
                @(negedge clk);
            end
            checks++;
            if (nb !== want || bad) begin
                failures++; $display("FAIL rand_beats x=%h rep=%0d beats=%0d exp=%0d stable_last_ok=%b", x, rep, nb, want, !bad);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_replay();
        test_corners();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
